alu_issue: RTL
==============

Name: alu_issue

Overview:
- Front end that drives the 32-bit ALU: accepts one decoded instruction per handshake and encodes it into the 4-bit ALU control code plus operands.
- Captures the ALU's result and zero flag, then presents a writeback/branch response downstream.
- Sits between the decode stage and the register-file writeback / PC-select logic of the riscv-32i multi-cycle core.
- The ALU itself stays combinational; this block supplies all of the sequencing.

Parameters:
- XLEN, 32, datapath width of operands and result.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  block can accept an instruction.
- opcode  input  7  instruction opcode field.
- funct3  input  3  instruction funct3 field.
- funct7_5  input  1  instruction bit 30.
- rs1_data  input  XLEN  source register 1 value.
- rs2_data  input  XLEN  source register 2 value.
- imm  input  XLEN  sign-extended immediate.
- rd  input  5  destination register index.
- alu_in1  output  XLEN  ALU operand 1 (registered).
- alu_in2  output  XLEN  ALU operand 2 (registered).
- alu_control  output  4  ALU operation code (registered).
- alu_result  input  XLEN  ALU result (combinational from alu_in1/alu_in2/alu_control).
- zero  input  1  ALU result-is-zero flag.
- out_valid  output  1  response present.
- out_ready  input  1  downstream accepts response.
- out_we  output  1  register write enable.
- out_rd  output  5  write destination.
- out_data  output  XLEN  write data.
- out_branch  output  1  response is a branch.
- out_taken  output  1  branch taken.
- out_illegal  output  1  unsupported encoding.

Behaviour:
- Reset: state IDLE. in_ready=1. out_valid, out_we, out_branch, out_taken and out_illegal are 0. out_rd=0, out_data=0, alu_in1=0, alu_in2=0, alu_control=4'b0000. The reset value of in_ready holds in the cycle after reset deasserts.
- Reset mid-operation: abandons the transaction; no response is ever produced for it.
- Decode, registered on accept:
  - opcode 0110011 (R-type), operand 2 = rs2_data:
    - funct3 000, funct7_5=0: ADD, code 0010.
    - funct3 000, funct7_5=1: SUB, code 0110.
    - funct3 111: AND, code 0000.
    - funct3 110: OR, code 0001.
    - funct3 010: SLT, code 0111.
  - opcode 0010011 (I-type), operand 2 = imm, funct7_5 ignored:
    - funct3 000: ADDI, code 0010.
    - funct3 111: ANDI, code 0000.
    - funct3 110: ORI, code 0001.
    - funct3 010: SLTI, code 0111.
  - opcode 1100011 (branch): code 0110 (SUB), operand 2 = rs2_data.
    - funct3 000: BEQ.
    - funct3 001: BNE.
  - Operand 1 is always rs1_data.
  - Any other opcode/funct combination is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready=1.
    - in_valid=1, legal encoding: latch operands, code, rd and kind; go to EXEC.
    - in_valid=1, illegal encoding: go directly to RESP with out_illegal=1, out_we=0, out_branch=0, out_data=0. ALU registers are left unchanged.
  - EXEC: in_ready=0. The ALU sees stable registered inputs. At the end of the cycle:
    - out_data <= alu_result.
    - out_taken <= zero for BEQ, !zero for BNE, 0 otherwise.
    - out_we <= 1 for R/I-type with rd!=0, else 0.
    - Go to RESP.
  - RESP: in_ready=0, out_valid=1. All out_* fields are held stable until out_ready=1, then go to IDLE.
    - out_ready is sampled only in RESP.
- Latency: accept at edge N; out_valid=1 after edge N+2 (after edge N+1 for an illegal encoding). Minimum of 3 cycles per legal instruction; no overlap between instructions.
- Branch responses: out_branch=1, out_we=0, and out_data carries the SUB result.
- The ALU result is used as-is: no widening or sign handling here; all arithmetic wraps at XLEN bits.
- out_valid is held while out_ready is low; no new instruction is accepted until the response is taken.

Test Plan:
- Reset, then R-type ADD: rs1=5, rs2=7, rd=3 → alu_control=0010 in EXEC; out_valid 2 cycles after accept with out_data=12, out_we=1, out_rd=3.
- R-type SUB wrap and x0: rs1=0, rs2=1, rd=0 → out_data=32'hFFFFFFFF, out_we=0. Then ORI: rs1=32'hF0, imm=32'h0F → out_data=32'hFF.
- BEQ with rs1=rs2=9 → out_branch=1, out_taken=1, out_we=0. BNE with the same operands → out_taken=0.
- Illegal encoding (opcode 0000011) → out_valid one cycle after accept, out_illegal=1, alu_control unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in RESP → out_* stable and in_ready=0 throughout; a new in_valid is ignored until the response is taken.
- Reset asserted in EXEC → next cycle in IDLE with all outputs at reset values; no out_valid is ever produced for the aborted instruction.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/response front end for the combinational 32-bit ALU of the multi-cycle RV32I core.
// Decodes one instruction per handshake, drives registered ALU inputs and returns a writeback/branch response.
module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      rd,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [3:0]      alu_control,
   input  logic [XLEN-1:0] alu_result,
   input  logic            zero,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_we,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_data,
   output logic            out_branch,
   output logic            out_taken,
   output logic            out_illegal
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state, state_next;

   logic       dec_legal;
   logic [3:0] dec_code;
   logic       dec_use_imm;
   logic       dec_branch;
   logic       dec_bne;

   logic       bne_q;
   logic       write_q;

   always_comb begin
      dec_legal   = 1'b0;
      dec_code    = 4'b0000;
      dec_use_imm = 1'b0;
      dec_branch  = 1'b0;
      dec_bne     = 1'b0;
      case (opcode)
         7'b0110011: begin
            case (funct3)
               3'b000: begin
                  dec_legal = 1'b1;
                  dec_code  = funct7_5 ? 4'b0110 : 4'b0010;
               end
               3'b111: begin dec_legal = 1'b1; dec_code = 4'b0000; end
               3'b110: begin dec_legal = 1'b1; dec_code = 4'b0001; end
               3'b010: begin dec_legal = 1'b1; dec_code = 4'b0111; end
               default: ;
            endcase
         end
         7'b0010011: begin
            dec_use_imm = 1'b1;
            case (funct3)
               3'b000: begin dec_legal = 1'b1; dec_code = 4'b0010; end
               3'b111: begin dec_legal = 1'b1; dec_code = 4'b0000; end
               3'b110: begin dec_legal = 1'b1; dec_code = 4'b0001; end
               3'b010: begin dec_legal = 1'b1; dec_code = 4'b0111; end
               default: ;
            endcase
         end
         7'b1100011: begin
            dec_code   = 4'b0110;
            dec_branch = 1'b1;
            case (funct3)
               3'b000: dec_legal = 1'b1;
               3'b001: begin dec_legal = 1'b1; dec_bne = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = dec_legal ? EXEC : RESP;
         EXEC: state_next = RESP;
         RESP: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RESP);

   // Illegal encodings skip EXEC, so the ALU registers keep whatever the last legal op left there.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_in1     <= '0;
         alu_in2     <= '0;
         alu_control <= 4'b0000;
         out_we      <= 1'b0;
         out_rd      <= 5'd0;
         out_data    <= '0;
         out_branch  <= 1'b0;
         out_taken   <= 1'b0;
         out_illegal <= 1'b0;
         bne_q       <= 1'b0;
         write_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  out_rd    <= rd;
                  out_we    <= 1'b0;
                  out_taken <= 1'b0;
                  if (dec_legal) begin
                     alu_in1     <= rs1_data;
                     alu_in2     <= dec_use_imm ? imm : rs2_data;
                     alu_control <= dec_code;
                     out_branch  <= dec_branch;
                     out_illegal <= 1'b0;
                     bne_q       <= dec_bne;
                     write_q     <= !dec_branch && (rd != 5'd0);
                  end else begin
                     out_branch  <= 1'b0;
                     out_illegal <= 1'b1;
                     out_data    <= '0;
                     write_q     <= 1'b0;
                  end
               end
            end
            EXEC: begin
               out_data  <= alu_result;
               out_taken <= out_branch && (bne_q ? !zero : zero);
               out_we    <= write_q;
            end
            default: ;
         endcase
      end
   end

endmodule
